// File: rtl/rv32i_commit_monitor.sv
// rv32i_commit_monitor: watches the retire stream beside writeback. It logs
// architectural side effects into a trace FIFO, tracks shadow x10/x17 for the
// riscv-tests exit convention, and keeps instret/cycle counters and a watchdog.
module rv32i_commit_monitor #(
  parameter int unsigned TRACE_DEPTH    = 16,
  parameter int unsigned HALT_MODE      = 0,
  parameter logic [31:0] EXIT_SYSCALL   = 32'h5d,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned COUNT_W        = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_restart,
  input  logic               i_commit,
  input  logic [31:0]        i_pc,
  input  logic               i_wr_rd,
  input  logic [4:0]         i_rd_addr,
  input  logic [31:0]        i_rd_data,
  input  logic               i_mem_wr,
  input  logic [31:0]        i_mem_addr,
  input  logic [31:0]        i_mem_data,
  input  logic [3:0]         i_mem_mask,
  input  logic               i_trap,
  input  logic [4:0]         i_trap_cause,
  input  logic               i_ecall,
  input  logic               i_ebreak,
  input  logic               i_illegal,
  output logic               o_rec_valid,
  input  logic               i_rec_ready,
  output logic [1:0]         o_rec_kind,
  output logic [31:0]        o_rec_pc,
  output logic [31:0]        o_rec_addr,
  output logic [31:0]        o_rec_data,
  output logic [3:0]         o_rec_mask,
  output logic               o_overflow,
  output logic [COUNT_W-1:0] o_drop_cnt,
  output logic [1:0]         o_state,
  output logic               o_pass,
  output logic               o_fail,
  output logic [31:0]        o_exit_code,
  output logic [COUNT_W-1:0] o_instret,
  output logic [COUNT_W-1:0] o_cycles
);

  localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);

  localparam logic [1:0] KIND_REG  = 2'd0;
  localparam logic [1:0] KIND_MEM  = 2'd1;
  localparam logic [1:0] KIND_TRAP = 2'd2;
  localparam logic [1:0] KIND_HALT = 2'd3;

  localparam logic [COUNT_W-1:0] CNT_ONE      = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]     PTR_ONE      = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    TIMEOUT = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } rec_t;

  state_e             state_q, state_d;
  logic [31:0]        x10_q, x10_d, x17_q, x17_d;
  logic               pass_q, pass_d, fail_q, fail_d;
  logic [31:0]        exitCode_q, exitCode_d;
  logic [COUNT_W-1:0] instret_q, instret_d;
  logic [COUNT_W-1:0] cycles_q, cycles_d;
  logic [COUNT_W-1:0] dropCnt_q, dropCnt_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  rec_t               mem_q [TRACE_DEPTH];

  rec_t               pushRec;
  rec_t               head;
  logic               push, pop, accept, drop, memWrite;
  logic               full, empty;
  logic               run, haltFlag, haltHit, timeoutHit;

  assign run   = (state_q == RUN);
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                 (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign head  = mem_q[rdPtr_q[PTR_W-1:0]];

  // Select which retiring-instruction flag ends the run for this build
  always_comb begin
    haltFlag = 1'b0;
    case (HALT_MODE)
      1:       haltFlag = i_ebreak;
      2:       haltFlag = i_ecall;
      3:       haltFlag = i_illegal;
      default: haltFlag = i_ecall | i_ebreak;
    endcase
  end

  assign haltHit    = run && i_commit && haltFlag;
  assign timeoutHit = run && (TIMEOUT_CYCLES != 0) && (cycles_q == TIMEOUT_LAST);

  // Next-state: counters, shadows, verdict, record selection and FIFO pointers
  always_comb begin
    state_d    = state_q;
    x10_d      = x10_q;
    x17_d      = x17_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    exitCode_d = exitCode_q;
    instret_d  = instret_q;
    cycles_d   = cycles_q;
    dropCnt_d  = dropCnt_q;
    overflow_d = overflow_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    pushRec    = '0;
    push       = 1'b0;

    if (run) begin
      if (cycles_q != '1) cycles_d = cycles_q + CNT_ONE;
      if (i_commit) begin
        if (instret_q != '1) instret_d = instret_q + CNT_ONE;
        if (i_wr_rd && i_rd_addr == 5'd10) x10_d = i_rd_data;
        if (i_wr_rd && i_rd_addr == 5'd17) x17_d = i_rd_data;
        pushRec.pc = i_pc;
        if (i_trap) begin
          push         = 1'b1;
          pushRec.kind = KIND_TRAP;
          pushRec.addr = {27'b0, i_trap_cause};
        end else if (i_mem_wr) begin
          push         = 1'b1;
          pushRec.kind = KIND_MEM;
          pushRec.addr = i_mem_addr;
          pushRec.data = i_mem_data;
          pushRec.mask = i_mem_mask;
        end else if (i_wr_rd && i_rd_addr != 5'd0) begin
          push         = 1'b1;
          pushRec.kind = KIND_REG;
          pushRec.addr = {27'b0, i_rd_addr};
          pushRec.data = i_rd_data;
        end
      end
      if (haltHit) begin
        state_d      = HALTED;
        pass_d       = (x17_d == EXIT_SYSCALL) && (x10_d == 32'd0);
        fail_d       = (x17_d == EXIT_SYSCALL) && (x10_d != 32'd0);
        exitCode_d   = {1'b0, x10_d[31:1]};
        push         = 1'b1;
        pushRec.kind = KIND_HALT;
        pushRec.addr = x17_d;
        pushRec.data = x10_d;
        pushRec.mask = {2'b00, pass_d, fail_d};
      end else if (timeoutHit) begin
        state_d = TIMEOUT;
        fail_d  = 1'b1;
      end
    end

    pop    = !empty && i_rec_ready;
    accept = push && (!full || pop);
    drop   = push && full && !pop;
    if (pop)    rdPtr_d = rdPtr_q + PTR_ONE;
    if (accept) wrPtr_d = wrPtr_q + PTR_ONE;
    if (drop) begin
      overflow_d = 1'b1;
      if (dropCnt_q != '1) dropCnt_d = dropCnt_q + CNT_ONE;
    end

    if (i_restart) begin
      state_d    = RUN;
      x10_d      = '0;
      x17_d      = '0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      exitCode_d = '0;
      instret_d  = '0;
      cycles_d   = '0;
      dropCnt_d  = '0;
      overflow_d = 1'b0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
    end
  end

  assign memWrite = accept && !i_restart;

  // Register all control state with asynchronous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RUN;
      x10_q      <= '0;
      x17_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      exitCode_q <= '0;
      instret_q  <= '0;
      cycles_q   <= '0;
      dropCnt_q  <= '0;
      overflow_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      state_q    <= state_d;
      x10_q      <= x10_d;
      x17_q      <= x17_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      exitCode_q <= exitCode_d;
      instret_q  <= instret_d;
      cycles_q   <= cycles_d;
      dropCnt_q  <= dropCnt_d;
      overflow_q <= overflow_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
    end
  end

  // Trace storage; contents are only observed through the valid-gated head
  always_ff @(posedge i_clk) begin
    if (memWrite) mem_q[wrPtr_q[PTR_W-1:0]] <= pushRec;
  end

  assign o_rec_valid = !empty;
  assign o_rec_kind  = empty ? 2'd0  : head.kind;
  assign o_rec_pc    = empty ? 32'd0 : head.pc;
  assign o_rec_addr  = empty ? 32'd0 : head.addr;
  assign o_rec_data  = empty ? 32'd0 : head.data;
  assign o_rec_mask  = empty ? 4'd0  : head.mask;
  assign o_overflow  = overflow_q;
  assign o_drop_cnt  = dropCnt_q;
  assign o_state     = state_q;
  assign o_pass      = pass_q;
  assign o_fail      = fail_q;
  assign o_exit_code = exitCode_q;
  assign o_instret   = instret_q;
  assign o_cycles    = cycles_q;

endmodule

// File: tb/tb_rv32i_commit_monitor.sv
// Testbench for rv32i_commit_monitor. Three instances share all inputs and
// differ only in HALT_MODE (0, 2, 3); TRACE_DEPTH = 4 and TIMEOUT_CYCLES = 50.
module tb_rv32i_commit_monitor;

  localparam int NI = 3;
  localparam int NV = 12;

  typedef struct {
    logic        commit;
    logic        wrRd;
    logic [4:0]  rd;
    logic [31:0] rdData;
    logic        memWr;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic [3:0]  mask;
    logic        trap;
    logic [4:0]  cause;
    logic        ecall;
    logic        ebreak;
    logic        illegal;
    logic [31:0] pc;
    logic        expValid;
    logic [1:0]  expKind;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic [3:0]  expMask;
    logic [1:0]  expState;
    logic [31:0] expInstret;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        restart;
  logic        commit;
  logic [31:0] pc;
  logic        wrRd;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic        memWr;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [3:0]  memMask;
  logic        trap;
  logic [4:0]  trapCause;
  logic        ecall;
  logic        ebreak;
  logic        illegal;
  logic        recReady;

  logic        recValid [NI];
  logic [1:0]  recKind  [NI];
  logic [31:0] recPc    [NI];
  logic [31:0] recAddr  [NI];
  logic [31:0] recData  [NI];
  logic [3:0]  recMask  [NI];
  logic        overflow [NI];
  logic [31:0] dropCnt  [NI];
  logic [1:0]  state    [NI];
  logic        pass     [NI];
  logic        fail     [NI];
  logic [31:0] exitCode [NI];
  logic [31:0] instret  [NI];
  logic [31:0] cycles   [NI];

  int checks = 0;
  int errors = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gInst
    localparam int unsigned MODE = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    rv32i_commit_monitor #(
      .TRACE_DEPTH(4), .HALT_MODE(MODE), .EXIT_SYSCALL(32'h5d),
      .TIMEOUT_CYCLES(50), .COUNT_W(32)
    ) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_restart(restart), .i_commit(commit),
      .i_pc(pc), .i_wr_rd(wrRd), .i_rd_addr(rdAddr), .i_rd_data(rdData),
      .i_mem_wr(memWr), .i_mem_addr(memAddr), .i_mem_data(memData),
      .i_mem_mask(memMask), .i_trap(trap), .i_trap_cause(trapCause),
      .i_ecall(ecall), .i_ebreak(ebreak), .i_illegal(illegal),
      .o_rec_valid(recValid[g]), .i_rec_ready(recReady),
      .o_rec_kind(recKind[g]), .o_rec_pc(recPc[g]), .o_rec_addr(recAddr[g]),
      .o_rec_data(recData[g]), .o_rec_mask(recMask[g]),
      .o_overflow(overflow[g]), .o_drop_cnt(dropCnt[g]), .o_state(state[g]),
      .o_pass(pass[g]), .o_fail(fail[g]), .o_exit_code(exitCode[g]),
      .o_instret(instret[g]), .o_cycles(cycles[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    commit = 1'b0; pc = '0; wrRd = 1'b0; rdAddr = '0; rdData = '0;
    memWr = 1'b0; memAddr = '0; memData = '0; memMask = '0;
    trap = 1'b0; trapCause = '0; ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    commit = v.commit; wrRd = v.wrRd; rdAddr = v.rd; rdData = v.rdData;
    memWr = v.memWr; memAddr = v.memAddr; memData = v.memData; memMask = v.mask;
    trap = v.trap; trapCause = v.cause; ecall = v.ecall; ebreak = v.ebreak;
    illegal = v.illegal; pc = v.pc;
  endtask

  task automatic doRestart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic regCommit(input logic [4:0] rd, input logic [31:0] data);
    clearInputs();
    commit = 1'b1; wrRd = 1'b1; rdAddr = rd; rdData = data;
    step();
    clearInputs();
  endtask

  task automatic popCheck(input int g, input string name, input logic [1:0] kind,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask);
    checkOutput({name, " valid"}, 32'(recValid[g]), 32'd1);
    checkOutput({name, " kind"},  32'(recKind[g]),  32'(kind));
    checkOutput({name, " addr"},  recAddr[g],       addr);
    checkOutput({name, " data"},  recData[g],       data);
    checkOutput({name, " mask"},  32'(recMask[g]),  32'(mask));
    recReady = 1'b1;
    step();
    recReady = 1'b0;
  endtask

  initial begin
    // Fields: commit wrRd rd rdData memWr memAddr memData mask trap cause ecall ebreak illegal pc
    //         | expValid expKind expAddr expData expMask expState expInstret
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h100,
                 1'b1, 2'd0, 32'h5, 32'hDEADBEEF, 4'h0, 2'd0, 32'd1};
    vecs[1]  = '{1'b1, 1'b1, 5'd0, 32'h00001234, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h104,
                 1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 2'd0, 32'd1};
    vecs[2]  = '{1'b1, 1'b1, 5'd3, 32'h00000055, 1'b1, 32'h1000, 32'h11223344, 4'hF, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h108,
                 1'b1, 2'd1, 32'h1000, 32'h11223344, 4'hF, 2'd0, 32'd1};
    vecs[3]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h2000, 32'hAA, 4'h3, 1'b1, 5'h0B, 1'b0, 1'b0, 1'b0, 32'h10C,
                 1'b1, 2'd2, 32'hB, 32'h0, 4'h0, 2'd0, 32'd1};
    vecs[4]  = '{1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 5'h11, 1'b0, 1'b0, 1'b0, 32'h110,
                 1'b1, 2'd2, 32'h11, 32'h0, 4'h0, 2'd0, 32'd1};
    vecs[5]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 32'h114,
                 1'b1, 2'd3, 32'h0, 32'h0, 4'h0, 2'd1, 32'd1};
    vecs[6]  = '{1'b1, 1'b1, 5'd17, 32'h5d, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 32'h118,
                 1'b1, 2'd3, 32'h5d, 32'h0, 4'h2, 2'd1, 32'd1};
    vecs[7]  = '{1'b1, 1'b1, 5'd10, 32'h5, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 32'h11C,
                 1'b1, 2'd3, 32'h0, 32'h5, 4'h0, 2'd1, 32'd1};
    vecs[8]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 5'h02, 1'b0, 1'b0, 1'b1, 32'h120,
                 1'b1, 2'd2, 32'h2, 32'h0, 4'h0, 2'd0, 32'd1};
    vecs[9]  = '{1'b0, 1'b1, 5'd5, 32'h99, 1'b1, 32'h3000, 32'h1, 4'hF, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 32'h124,
                 1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 2'd0, 32'd0};
    vecs[10] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h4000, 32'h2, 4'h1, 1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 32'h128,
                 1'b1, 2'd3, 32'h0, 32'h0, 4'h0, 2'd1, 32'd1};
    vecs[11] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h5004, 32'hCAFEF00D, 4'b0101, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h12C,
                 1'b1, 2'd1, 32'h5004, 32'hCAFEF00D, 4'b0101, 2'd0, 32'd1};

    clearInputs();
    restart  = 1'b0;
    recReady = 1'b0;
    rstN     = 1'b0;
    #12;
    checkOutput("reset state",    32'(state[0]),    32'd0);
    checkOutput("reset instret",  instret[0],       32'd0);
    checkOutput("reset cycles",   cycles[0],        32'd0);
    checkOutput("reset valid",    32'(recValid[0]), 32'd0);
    checkOutput("reset pass",     32'(pass[0]),     32'd0);
    checkOutput("reset fail",     32'(fail[0]),     32'd0);
    checkOutput("reset overflow", 32'(overflow[0]), 32'd0);
    checkOutput("reset dropCnt",  dropCnt[0],       32'd0);
    checkOutput("reset exitCode", exitCode[0],      32'd0);
    rstN = 1'b1;
    step();

    // Single-commit record generation and priority table
    for (int i = 0; i < NV; i++) begin
      doRestart();
      applyStimulus(vecs[i]);
      step();
      clearInputs();
      checkOutput($sformatf("v%0d valid", i), 32'(recValid[0]), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("v%0d kind", i), 32'(recKind[0]), 32'(vecs[i].expKind));
        checkOutput($sformatf("v%0d addr", i), recAddr[0], vecs[i].expAddr);
        checkOutput($sformatf("v%0d data", i), recData[0], vecs[i].expData);
        checkOutput($sformatf("v%0d mask", i), 32'(recMask[0]), 32'(vecs[i].expMask));
        checkOutput($sformatf("v%0d pc", i),   recPc[0],   vecs[i].pc);
      end
      checkOutput($sformatf("v%0d state", i),   32'(state[0]), 32'(vecs[i].expState));
      checkOutput($sformatf("v%0d instret", i), instret[0],    vecs[i].expInstret);
    end

    // Pass exit through ecall
    doRestart();
    regCommit(5'd17, 32'h5d);
    regCommit(5'd10, 32'h0);
    commit = 1'b1; ecall = 1'b1; pc = 32'h208;
    step();
    clearInputs();
    checkOutput("pass state",    32'(state[0]), 32'd1);
    checkOutput("pass pass",     32'(pass[0]),  32'd1);
    checkOutput("pass fail",     32'(fail[0]),  32'd0);
    checkOutput("pass instret",  instret[0],    32'd3);
    checkOutput("pass cycles",   cycles[0],     32'd3);
    checkOutput("pass exitCode", exitCode[0],   32'd0);
    checkOutput("mode3 ecall state", 32'(state[2]), 32'd0);
    regCommit(5'd5, 32'h9);
    checkOutput("halted instret frozen", instret[0], 32'd3);
    popCheck(0, "pass rec0", 2'd0, 32'd17, 32'h5d, 4'h0);
    popCheck(0, "pass rec1", 2'd0, 32'd10, 32'h0,  4'h0);
    popCheck(0, "pass rec2", 2'd3, 32'h5d, 32'h0,  4'b0010);
    checkOutput("pass drained", 32'(recValid[0]), 32'd0);
    checkOutput("halted cycles frozen", cycles[0], 32'd3);

    // Fail exit through ebreak; HALT_MODE 2 must ignore the ebreak
    doRestart();
    recReady = 1'b1;
    regCommit(5'd17, 32'h5d);
    regCommit(5'd10, 32'h7);
    commit = 1'b1; ebreak = 1'b1;
    step();
    clearInputs();
    recReady = 1'b0;
    checkOutput("fail state",    32'(state[0]), 32'd1);
    checkOutput("fail fail",     32'(fail[0]),  32'd1);
    checkOutput("fail pass",     32'(pass[0]),  32'd0);
    checkOutput("fail exitCode", exitCode[0],   32'd3);
    checkOutput("mode2 ebreak state", 32'(state[1]), 32'd0);
    checkOutput("mode2 ebreak fail",  32'(fail[1]),  32'd0);

    // Overflow with a 4-deep FIFO, then push+pop while full
    doRestart();
    for (int i = 0; i < 6; i++) begin
      commit = 1'b1; memWr = 1'b1; memAddr = 32'h100 + 32'(4 * i);
      memData = 32'(i); memMask = 4'hF;
      step();
    end
    clearInputs();
    checkOutput("ovf overflow", 32'(overflow[0]), 32'd1);
    checkOutput("ovf dropCnt",  dropCnt[0],       32'd2);
    checkOutput("ovf head addr", recAddr[0],      32'h100);
    commit = 1'b1; memWr = 1'b1; memAddr = 32'h200; memData = 32'h99; memMask = 4'hF;
    recReady = 1'b1;
    step();
    clearInputs();
    recReady = 1'b0;
    checkOutput("full push+pop dropCnt", dropCnt[0], 32'd2);
    popCheck(0, "ovf rec0", 2'd1, 32'h104, 32'd1,  4'hF);
    popCheck(0, "ovf rec1", 2'd1, 32'h108, 32'd2,  4'hF);
    popCheck(0, "ovf rec2", 2'd1, 32'h10C, 32'd3,  4'hF);
    popCheck(0, "ovf rec3", 2'd1, 32'h200, 32'h99, 4'hF);
    checkOutput("ovf drained", 32'(recValid[0]), 32'd0);

    // Illegal instruction halts only the HALT_MODE 3 instance
    doRestart();
    commit = 1'b1; illegal = 1'b1; trap = 1'b1; trapCause = 5'h02;
    wrRd = 1'b1; rdAddr = 5'd17; rdData = 32'h5d; pc = 32'h300;
    step();
    clearInputs();
    checkOutput("mode0 illegal kind", 32'(recKind[0]), 32'd2);
    checkOutput("mode0 illegal addr", recAddr[0],      32'h2);
    checkOutput("mode3 illegal state", 32'(state[2]),  32'd1);
    checkOutput("mode3 illegal pass",  32'(pass[2]),   32'd1);
    popCheck(2, "mode3 halt rec", 2'd3, 32'h5d, 32'h0, 4'b0010);
    checkOutput("mode3 single record", 32'(recValid[2]), 32'd0);

    // Watchdog timeout after 50 RUN cycles, then restart
    doRestart();
    for (int i = 0; i < 49; i++) step();
    checkOutput("pre-timeout state",  32'(state[0]), 32'd0);
    checkOutput("pre-timeout cycles", cycles[0],     32'd49);
    step();
    checkOutput("timeout state",  32'(state[0]), 32'd2);
    checkOutput("timeout cycles", cycles[0],     32'd50);
    checkOutput("timeout fail",   32'(fail[0]),  32'd1);
    checkOutput("timeout pass",   32'(pass[0]),  32'd0);
    regCommit(5'd5, 32'h1);
    checkOutput("timeout instret", instret[0],       32'd0);
    checkOutput("timeout no rec",  32'(recValid[0]), 32'd0);
    checkOutput("timeout frozen",  cycles[0],        32'd50);
    doRestart();
    checkOutput("restart state",   32'(state[0]), 32'd0);
    checkOutput("restart cycles",  cycles[0],     32'd0);
    checkOutput("restart instret", instret[0],    32'd0);
    checkOutput("restart fail",    32'(fail[0]),  32'd0);
    step();
    checkOutput("restart counting", cycles[0], 32'd1);

    // Asynchronous reset in the middle of a run
    doRestart();
    regCommit(5'd17, 32'h5d);
    regCommit(5'd10, 32'h0);
    for (int i = 0; i < 17; i++) regCommit(5'd1, 32'(i));
    commit = 1'b1; ecall = 1'b1;
    step();
    clearInputs();
    checkOutput("midrun instret", instret[0],    32'd20);
    checkOutput("midrun pass",    32'(pass[0]),  32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async state",   32'(state[0]),    32'd0);
    checkOutput("async instret", instret[0],       32'd0);
    checkOutput("async valid",   32'(recValid[0]), 32'd0);
    checkOutput("async pass",    32'(pass[0]),     32'd0);
    checkOutput("async fail",    32'(fail[0]),     32'd0);
    rstN = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_commit_monitor.md
Name: rv32i_commit_monitor

Overview:
- Synthesizable commit-stream monitor for the rv32i core; sits beside the writeback stage of the SoC.
- Records architectural side effects into a trace FIFO: base-register writes, data-memory writes, traps, and halt.
- Tracks shadow copies of x10/x17 and evaluates the riscv-tests exit convention (x17 == 0x5d, x10 == 0 → pass).
- Provides a parametrised halt mode, a watchdog timeout, and instret/cycle counters, so the same checks run on FPGA and in simulation.

Parameters:
TRACE_DEPTH, 16, trace FIFO entries; power of 2, ≥2
HALT_MODE, 0, 0=ecall|ebreak, 1=ebreak only, 2=ecall only, 3=illegal instruction only
EXIT_SYSCALL, 32'h5d, x17 value identifying an exit call
TIMEOUT_CYCLES, 100000, RUN cycles before timeout; 0 disables the watchdog
COUNT_W, 32, width of the instret, cycle and drop counters

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_restart  in  1  synchronous: clear counters/FIFO/verdict, return to RUN
i_commit  in  1  one instruction retires this cycle
i_pc  in  32  PC of retiring instruction
i_wr_rd  in  1  retiring instruction writes rd
i_rd_addr  in  5  rd index
i_rd_data  in  32  rd value
i_mem_wr  in  1  retiring instruction writes memory
i_mem_addr  in  32  store address
i_mem_data  in  32  store data
i_mem_mask  in  4  byte mask
i_trap  in  1  commit enters trap
i_trap_cause  in  5  {intbit, code[3:0]}
i_ecall  in  1  retiring instruction is ecall
i_ebreak  in  1  retiring instruction is ebreak
i_illegal  in  1  retiring instruction is illegal
o_rec_valid  out  1  trace head valid
i_rec_ready  in  1  consumer pops head
o_rec_kind  out  2  0=REG, 1=MEM, 2=TRAP, 3=HALT
o_rec_pc  out  32  record PC
o_rec_addr  out  32  see Behaviour
o_rec_data  out  32  see Behaviour
o_rec_mask  out  4  see Behaviour
o_overflow  out  1  sticky: at least one record was dropped
o_drop_cnt  out  COUNT_W  saturating count of dropped records
o_state  out  2  0=RUN, 1=HALTED, 2=TIMEOUT
o_pass  out  1  verdict pass
o_fail  out  1  verdict fail
o_exit_code  out  32  x10 >> 1 latched at halt
o_instret  out  COUNT_W  commits counted in RUN
o_cycles  out  COUNT_W  cycles spent in RUN

Behaviour:
- Reset:
  - State is RUN.
  - All outputs and counters are 0; the FIFO is empty.
  - Shadow x10 and x17 are 0.
  - i_restart has the same effect, synchronously, and takes priority over all other events in that cycle.
- RUN state:
  - o_cycles increments every cycle.
  - o_instret increments on each i_commit.
  - Inputs other than i_commit are ignored when i_commit = 0.
- Shadow registers: on commit with i_wr_rd && rd == 10 (or rd == 17), update shadow x10 (or x17) in the same cycle. Writes to rd 0 are ignored.
- Record generation: at most one record per commit, in this priority order:
  1. i_trap → TRAP record: addr = {27'b0, cause}, data = 0, mask = 0.
  2. i_mem_wr → MEM record: addr, data and mask taken from the store.
  3. i_wr_rd && rd != 0 → REG record: addr = {27'b0, rd}, data = rd value, mask = 0.
  4. Otherwise no record.
- Halt condition: commit with the HALT_MODE-selected flag(s) set. On that cycle:
  - The HALT record replaces any other record for that commit.
  - HALT record fields: addr = shadow x17, data = shadow x10, mask = {2'b0, pass, fail}.
  - Verdict, evaluated with shadow values that include that commit's own rd write:
    - x17 == EXIT_SYSCALL && x10 == 0 → pass = 1.
    - x17 == EXIT_SYSCALL && x10 != 0 → fail = 1.
    - Otherwise both are 0 (unknown).
  - o_exit_code = x10 >> 1.
  - Next state is HALTED. The halting commit counts in o_instret.
- HALTED / TIMEOUT states:
  - Commits are ignored and counters freeze.
  - The FIFO remains drainable.
  - Only reset or i_restart leaves these states.
- Timeout: when o_cycles reaches TIMEOUT_CYCLES while in RUN, the next state is TIMEOUT, o_fail = 1, and no record is written. A halt commit in the same cycle takes priority over the timeout.
- FIFO:
  - Registered head; a record is visible on o_rec_* the cycle after its push.
  - Pop occurs when o_rec_valid && i_rec_ready.
  - Push into a full FIFO with a simultaneous pop is accepted.
  - Push into a full FIFO without a pop drops the record: o_overflow sets, and o_drop_cnt increments, saturating at all-ones.
  - A HALT record that would be dropped also sets o_overflow; verdict outputs are still valid.
  - Pointers wrap modulo TRACE_DEPTH; full/empty are resolved with an extra pointer bit.
- Counters saturate at all-ones (no wrap).

Test Plan:
- Reset mid-run: run 20 commits, pulse i_rst_n low → o_state = 0, o_instret = 0, FIFO empty, o_pass/o_fail = 0 immediately (asynchronous).
- Pass exit: commits with rd=17←0x5d, rd=10←0, then ecall (HALT_MODE=0) → records REG(17,0x5d), REG(10,0), HALT(addr 0x5d, data 0, mask 4'b0010); o_pass = 1; o_state = 1; o_instret = 3.
- Fail exit: x17←0x5d, x10←0x7 (e.g. add to x10 = 0x7) then ebreak → o_fail = 1, o_exit_code = 3. With HALT_MODE = 2 the same ebreak does not halt; state stays RUN.
- Overflow: TRACE_DEPTH = 4, i_rec_ready = 0, 6 store commits → 4 MEM records retained, o_drop_cnt = 2, o_overflow = 1. With a full FIFO and simultaneous push+pop, the count stays at 4 and there is no drop.
- Priority: a single commit with i_trap = 1, cause 5'h0B and i_mem_wr = 1 → one TRAP record, addr = 0xB. An illegal-instruction commit with HALT_MODE = 3 → HALT record only.
- Timeout: TIMEOUT_CYCLES = 50, no halt → o_state = 2 at o_cycles = 50, o_fail = 1, later commits ignored. i_restart → RUN with all counters 0.
